// File: rtl/stall_ctrl.sv
// Hazard/stall controller: detects Tuse/Tnew data hazards, sequences the multiply/divide unit,
// and drives pipeline enables, bubble insertion and a saturating stall-cycle counter.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        is_md_D,
    input  logic [4:0]  wdes_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wdes_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        stall,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic        md_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             h_rs, h_rt, h_md;

    // A consumer stalls only when its producer's result arrives later than the consumer needs it.
    assign h_rs = (rs_D != 5'd0) &&
                  (((rs_D == wdes_E) && (tuse_rs_D < tnew_E)) ||
                   ((rs_D == wdes_M) && (tuse_rs_D < tnew_M)));
    assign h_rt = (rt_D != 5'd0) &&
                  (((rt_D == wdes_E) && (tuse_rt_D < tnew_E)) ||
                   ((rt_D == wdes_M) && (tuse_rt_D < tnew_M)));
    assign h_md = is_md_D && (mdu_busy || md_start_E);

    assign stall = !reset && (h_rs || h_rt || h_md);
    assign pc_en = !stall;
    assign d_en  = !stall;
    assign e_clr = stall;

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mdu_start = 1'b0;
        mdu_busy  = 1'b0;
        mdu_done  = 1'b0;
        case (state)
            IDLE: begin
                if (md_start_E) begin
                    mdu_start = 1'b1;
                    count_nxt = md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mdu_busy = 1'b1;
                if (count == CNT_W'(1)) begin
                    mdu_done  = 1'b1;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A start request seen while reset is held must not reach the MDU.
        mdu_start = mdu_start && !reset;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A start while BUSY is ignored by the FSM but latched here until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_err <= 1'b0;
        end else if (state == BUSY && md_start_E) begin
            md_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
